multicycle_control: RTL

Parametrised multicycle control unit for the 3-bit-opcode CPU; it replaces single-cycle opcode decoding with a FETCH/DECODE/EXEC/MEM/WB state machine. The block sequences one shared instruction/data memory through a req/ready handshake. It drives PC, IR, register-file, ALU and memory control strobes per state and adds HALT, an illegal-opcode flag, a memory-timeout bus error and a retire pulse. It sits between the IR opcode field and the datapath muxes and enables.

---
 rtl/control_pkg.sv | 45 ++++
 rtl/op_decode.sv | 64 ++++++
 rtl/multicycle_control.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states and
// the datapath mux encodings the control unit drives.
package control_pkg;

    // Opcode values of the 3-bit ISA (low bits of the IR opcode field).
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SLI  = 3'b001;
    localparam logic [2:0] OP_J    = 3'b010;
    localparam logic [2:0] OP_JAL  = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    // PC source select.
    localparam logic [1:0] PC_SRC_INC  = 2'b00;
    localparam logic [1:0] PC_SRC_BR   = 2'b01;
    localparam logic [1:0] PC_SRC_JMP  = 2'b10;

    // ALU operation select.
    localparam logic [1:0] ALU_OP_ADD  = 2'b00;
    localparam logic [1:0] ALU_OP_SUB  = 2'b01;
    localparam logic [1:0] ALU_OP_SLI  = 2'b10;
    localparam logic [1:0] ALU_OP_ADDR = 2'b11;

    // Register-file destination select.
    localparam logic [1:0] REG_DST_RT  = 2'b00;
    localparam logic [1:0] REG_DST_RD  = 2'b01;
    localparam logic [1:0] REG_DST_RA  = 2'b10;

    // Register-file write-data select.
    localparam logic [1:0] MTR_ALU     = 2'b00;
    localparam logic [1:0] MTR_MEM     = 2'b01;
    localparam logic [1:0] MTR_PC      = 2'b10;

endpackage

// File: rtl/op_decode.sv
// Combinational decode of the latched opcode into datapath selects and
// instruction-class flags; shared by the EXEC and WB output logic.
module op_decode
    import control_pkg::*;
(
    input  logic [2:0] i_op,
    output logic [1:0] o_alu_op,
    output logic       o_alu_src,
    output logic       o_sign_or_zero,
    output logic [1:0] o_reg_dst,
    output logic [1:0] o_mem_to_reg,
    output logic       o_is_mem,
    output logic       o_is_jump,
    output logic       o_is_branch
);

    // Per-opcode datapath settings; anything not named keeps its default.
    always_comb begin
        o_alu_op       = ALU_OP_ADD;
        o_alu_src      = 1'b0;
        o_sign_or_zero = 1'b1;
        o_reg_dst      = REG_DST_RT;
        o_mem_to_reg   = MTR_ALU;
        o_is_mem       = 1'b0;
        o_is_jump      = 1'b0;
        o_is_branch    = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_reg_dst = REG_DST_RD;
            end
            OP_SLI: begin
                o_alu_op       = ALU_OP_SLI;
                o_alu_src      = 1'b1;
                o_sign_or_zero = 1'b0;
            end
            OP_J: begin
                o_is_jump = 1'b1;
            end
            OP_JAL: begin
                o_is_jump    = 1'b1;
                o_reg_dst    = REG_DST_RA;
                o_mem_to_reg = MTR_PC;
            end
            OP_LW: begin
                o_alu_op     = ALU_OP_ADDR;
                o_alu_src    = 1'b1;
                o_is_mem     = 1'b1;
                o_mem_to_reg = MTR_MEM;
            end
            OP_SW: begin
                o_alu_op  = ALU_OP_ADDR;
                o_alu_src = 1'b1;
                o_is_mem  = 1'b1;
            end
            OP_BEQ: begin
                o_alu_op    = ALU_OP_SUB;
                o_is_branch = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer for the 3-bit
// opcode CPU with a single shared memory, memory timeout and status flags.
//
// Memory handshake: mem_req is raised in FETCH/MEM and held every cycle until
// the cycle in which mem_ready is seen high; that cycle completes the transfer.
// Only a timeout or reset withdraws a request before mem_ready.
module multicycle_control
    import control_pkg::*;
#(
    parameter int OPCODE_W    = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic                alu_src,
    output logic                sign_or_zero,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic [1:0]          alu_op,
    output logic [2:0]          state_o,
    output logic                halted,
    output logic                illegal_op,
    output logic                bus_error,
    output logic                retired
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    state_t           r_state;
    logic [2:0]       r_op_q;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_halted;
    logic             r_illegal;
    logic             r_bus_error;

    logic [1:0] w_alu_op;
    logic       w_alu_src;
    logic       w_sign_or_zero;
    logic [1:0] w_reg_dst;
    logic [1:0] w_mem_to_reg;
    logic       w_is_mem;
    logic       w_is_jump;
    logic       w_is_branch;
    logic       w_is_sw;
    logic       w_mem_state;
    logic       w_timeout;
    logic       w_illegal;

    op_decode u_op_decode (
        .i_op           (r_op_q),
        .o_alu_op       (w_alu_op),
        .o_alu_src      (w_alu_src),
        .o_sign_or_zero (w_sign_or_zero),
        .o_reg_dst      (w_reg_dst),
        .o_mem_to_reg   (w_mem_to_reg),
        .o_is_mem       (w_is_mem),
        .o_is_jump      (w_is_jump),
        .o_is_branch    (w_is_branch)
    );

    assign w_is_sw     = (r_op_q == OP_SW);
    assign w_mem_state = (r_state == FETCH) || (r_state == MEM);
    // Timeout fires on the cycle the wait counter reaches the limit.
    assign w_timeout   = (MEM_TIMEOUT != 0) && w_mem_state && (r_wait_cnt == TIMEOUT_VAL);
    // Any opcode value beyond the 3-bit ISA is illegal (only possible when OPCODE_W > 3).
    assign w_illegal   = (32'(opcode) >= 32'd8);

    // State sequencing, opcode latch, wait counter and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FETCH;
            r_op_q      <= OP_ADD;
            r_wait_cnt  <= '0;
            r_halted    <= 1'b0;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            if ((MEM_TIMEOUT != 0) && w_mem_state && !mem_ready && !w_timeout)
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            else
                r_wait_cnt <= '0;

            case (r_state)
                FETCH: begin
                    if (w_timeout) begin
                        r_state     <= HALT;
                        r_halted    <= 1'b1;
                        r_bus_error <= 1'b1;
                    end else if (mem_ready) begin
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    r_op_q <= opcode[2:0];
                    if (w_illegal) begin
                        r_illegal <= 1'b1;
                        r_state   <= FETCH;
                    end else if (opcode[2:0] == OP_HALT) begin
                        r_halted <= 1'b1;
                        r_state  <= HALT;
                    end else begin
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (w_is_mem)
                        r_state <= MEM;
                    else if (w_is_jump || w_is_branch)
                        r_state <= FETCH;
                    else
                        r_state <= WB;
                end
                MEM: begin
                    if (w_timeout) begin
                        r_state     <= HALT;
                        r_halted    <= 1'b1;
                        r_bus_error <= 1'b1;
                    end else if (mem_ready) begin
                        r_state <= w_is_sw ? FETCH : WB;
                    end
                end
                WB:      r_state <= FETCH;
                HALT:    r_state <= HALT;
                default: r_state <= FETCH;
            endcase
        end
    end

    // Per-state strobes; reset forces every output to its reset value at once.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_INC;
        reg_write    = 1'b0;
        alu_src      = 1'b0;
        sign_or_zero = 1'b1;
        reg_dst      = REG_DST_RT;
        mem_to_reg   = MTR_ALU;
        alu_op       = ALU_OP_ADD;
        retired      = 1'b0;
        if (!reset) begin
            case (r_state)
                FETCH: begin
                    if (!w_timeout) begin
                        mem_req = 1'b1;
                        if (mem_ready) begin
                            ir_write = 1'b1;
                            pc_write = 1'b1;
                        end
                    end
                end
                DECODE: begin
                    retired = w_illegal;
                end
                EXEC: begin
                    alu_op       = w_alu_op;
                    alu_src      = w_alu_src;
                    sign_or_zero = w_sign_or_zero;
                    if (w_is_jump) begin
                        pc_write   = 1'b1;
                        pc_src     = PC_SRC_JMP;
                        reg_write  = (r_op_q == OP_JAL);
                        reg_dst    = w_reg_dst;
                        mem_to_reg = w_mem_to_reg;
                        retired    = 1'b1;
                    end else if (w_is_branch) begin
                        pc_write = zero;
                        pc_src   = PC_SRC_BR;
                        retired  = 1'b1;
                    end
                end
                MEM: begin
                    if (!w_timeout) begin
                        mem_req = 1'b1;
                        iord    = 1'b1;
                        mem_we  = w_is_sw;
                        retired = w_is_sw && mem_ready;
                    end
                end
                WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = w_reg_dst;
                    mem_to_reg = w_mem_to_reg;
                    retired    = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign state_o    = reset ? 3'(FETCH) : r_state;
    assign halted     = r_halted    && !reset;
    assign illegal_op = r_illegal   && !reset;
    assign bus_error  = r_bus_error && !reset;

endmodule
